// File: rtl/piso_feeder.sv
// Parallel-in/serial-out feeder: WIDTH-bit words in over valid/ready, one bit per clock on dout.
// Latency: a word accepted at edge k drives its first bit after edge k and its last after edge k+WIDTH-1.
// Backpressure: load_ready = !buf_full (registered); one word may wait in the holding buffer while another shifts.
module piso_feeder #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state,    state_n;
    logic [WIDTH-1:0] sreg,     sreg_n;
    logic [CW-1:0]    cnt,      cnt_n;
    logic [WIDTH-1:0] buf_dat,  buf_dat_n;
    logic             buf_full, buf_full_n;
    logic             dout_n;
    logic             dout_valid_n;
    logic             frame_done_n;
    logic             accept;

    // The output end of the shift register depends on bit order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign load_ready = !buf_full;
    assign accept     = load_valid && load_ready;
    assign busy       = (state == ST_SHIFT);

    always_comb begin
        state_n    = state;
        sreg_n     = sreg;
        cnt_n      = cnt;
        buf_dat_n  = buf_dat;
        buf_full_n = buf_full;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    sreg_n  = load_data;
                    cnt_n   = '0;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt != LAST) begin
                    sreg_n = shift_one(sreg);
                    cnt_n  = cnt + CW'(1);
                    if (accept) begin
                        buf_dat_n  = load_data;
                        buf_full_n = 1'b1;
                    end
                end else if (buf_full) begin
                    sreg_n     = buf_dat;
                    buf_full_n = 1'b0;
                    cnt_n      = '0;
                end else if (accept) begin
                    // Direct load on the last-bit edge keeps the stream gapless.
                    sreg_n = load_data;
                    cnt_n  = '0;
                end else begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                cnt_n      = '0;
                buf_full_n = 1'b0;
            end
        endcase

        dout_n       = (state_n == ST_SHIFT) ? head_bit(sreg_n) : IDLE_LEVEL;
        dout_valid_n = (state_n == ST_SHIFT);
        frame_done_n = (state_n == ST_SHIFT) && (cnt_n == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            buf_dat    <= '0;
            buf_full   <= 1'b0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            cnt        <= cnt_n;
            buf_dat    <= buf_dat_n;
            buf_full   <= buf_full_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_piso_feeder.sv
// Bench for piso_feeder: bit-queue reference model for the MSB-first instance, direct checks for LSB-first.
module tb_piso_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_valid = 1'b0;
    logic       load_ready, dout, dout_valid, frame_done, busy;

    logic [7:0] ld2 = '0;
    logic       lv2 = 1'b0;
    logic       rdy2, d2, dv2, fd2, busy2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic b;
        logic last;
    } mbit_t;

    mbit_t q[$];
    logic  e_dout = 1'b0, e_vld = 1'b0, e_fd = 1'b0, e_rdy = 1'b1;

    piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
        .frame_done(frame_done), .busy(busy)
    );

    piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .load_data(ld2), .load_valid(lv2),
        .load_ready(rdy2), .dout(d2), .dout_valid(dv2),
        .frame_done(fd2), .busy(busy2)
    );

    always #5 clk = ~clk;

    // One clock of the reference model: a transfer appends the word's bits MSB first,
    // and every clock one pending bit (if any) appears on dout.
    task automatic tick(input logic v, input logic [7:0] d);
        logic acc;
        mbit_t m;
        load_valid = v;
        load_data  = d;
        acc = v && (q.size() < 8);
        @(posedge clk);
        if (acc)
            for (int i = 0; i < 8; i++) begin
                m.b    = d[7-i];
                m.last = (i == 7);
                q.push_back(m);
            end
        if (q.size() > 0) begin
            m = q.pop_front();
            e_dout = m.b; e_vld = 1'b1; e_fd = m.last;
        end else begin
            e_dout = 1'b0; e_vld = 1'b0; e_fd = 1'b0;
        end
        e_rdy = (q.size() < 8);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got=%b exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 8'h00);
            checks++; if (dout !== 1'b0 || dout_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || frame_done !== 1'b0) begin
                errors++; $display("FAIL idle cyc=%0d got dout=%b vld=%b busy=%b rdy=%b fd=%b exp 0,0,0,1,0", c, dout, dout_valid, busy, load_ready, frame_done);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] w = 8'hD6;
        for (int c = 0; c < 10; c++) begin
            tick(c == 0, w);
            checks++; if (dout !== (c < 8 ? w[7-c] : 1'b0)) begin errors++; $display("FAIL single_dout cyc=%0d got=%b exp=%b", c, dout, (c < 8 ? w[7-c] : 1'b0)); end
            checks++; if (dout_valid !== (c < 8) || busy !== (c < 8)) begin errors++; $display("FAIL single_vld cyc=%0d got vld=%b busy=%b exp=%b", c, dout_valid, busy, (c < 8)); end
            checks++; if (frame_done !== (c == 7)) begin errors++; $display("FAIL single_fd cyc=%0d got=%b exp=%b", c, frame_done, (c == 7)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got = '0;
        logic [15:0] fdm = '0;
        logic [15:0] rdym = '0;
        for (int c = 0; c < 16; c++) begin
            tick(c < 2, c == 0 ? 8'hA5 : 8'h3C);
            got[15-c]  = dout;
            fdm[15-c]  = frame_done;
            rdym[15-c] = load_ready;
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_vld cyc=%0d got=%b exp=1", c, dout_valid); end
            checks++; if (dout !== e_dout || frame_done !== e_fd || load_ready !== e_rdy) begin
                errors++; $display("FAIL b2b_model cyc=%0d got dout=%b fd=%b rdy=%b exp %b,%b,%b", c, dout, frame_done, load_ready, e_dout, e_fd, e_rdy);
            end
        end
        checks++; if (got !== 16'hA53C) begin errors++; $display("FAIL b2b_stream got=%h exp=a53c", got); end
        checks++; if (fdm !== 16'h0101) begin errors++; $display("FAIL b2b_frame_done got=%h exp=0101", fdm); end
        // ready is low after the buffered accept (cycles 1..7) and returns once the word starts shifting
        checks++; if (rdym !== 16'h80FF) begin errors++; $display("FAIL b2b_ready got=%h exp=80ff", rdym); end
        tick(1'b0, 8'h00);
        checks++; if (dout_valid !== 1'b0 || dout !== 1'b0) begin errors++; $display("FAIL b2b_end got vld=%b dout=%b exp 0,0", dout_valid, dout); end
    endtask

    task automatic test_last_edge_load();
        logic [15:0] got = '0;
        for (int c = 0; c < 16; c++) begin
            tick(c == 0 || c == 8, c == 0 ? 8'hF0 : 8'h0F);
            got[15-c] = dout;
            checks++; if (dout_valid !== 1'b1 || frame_done !== e_fd) begin
                errors++; $display("FAIL lastedge cyc=%0d got vld=%b fd=%b exp 1,%b", c, dout_valid, frame_done, e_fd);
            end
        end
        checks++; if (got !== 16'hF00F) begin errors++; $display("FAIL lastedge_stream got=%h exp=f00f", got); end
        tick(1'b0, 8'h00);
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL lastedge_end got=%b exp=0", dout_valid); end
    endtask

    task automatic test_mid_frame_reset();
        for (int c = 0; c < 3; c++) tick(c == 0, 8'hFF);
        checks++; if (dout !== 1'b1 || dout_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got dout=%b vld=%b exp 1,1", dout, dout_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dout !== 1'b0 || dout_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL rst_async got dout=%b vld=%b rdy=%b busy=%b fd=%b exp 0,0,1,0,0", dout, dout_valid, load_ready, busy, frame_done);
        end
        q.delete();
        e_dout = 1'b0; e_vld = 1'b0; e_fd = 1'b0; e_rdy = 1'b1;
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 8'h00);
            checks++; if (dout !== 1'b0 || dout_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rst_after cyc=%0d got dout=%b vld=%b busy=%b exp 0,0,0", c, dout, dout_valid, busy);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        for (int t = 0; t < 3; t++) begin
            w = (t == 0) ? 8'h01 : 8'($urandom);
            lv2 = 1'b1; ld2 = w;
            @(posedge clk); #1;
            lv2 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                checks++; if (d2 !== w[i] || dv2 !== 1'b1 || fd2 !== (i == 7)) begin
                    errors++; $display("FAIL lsb w=%h bit=%0d got dout=%b vld=%b fd=%b exp %b,1,%b", w, i, d2, dv2, fd2, w[i], (i == 7));
                end
                @(posedge clk); #1;
            end
            checks++; if (dv2 !== 1'b0 || d2 !== 1'b0 || busy2 !== 1'b0 || rdy2 !== 1'b1) begin
                errors++; $display("FAIL lsb_end got vld=%b dout=%b busy=%b rdy=%b exp 0,0,0,1", dv2, d2, busy2, rdy2);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            tick($urandom_range(0, 3) != 0, 8'($urandom));
            checks++; if (dout !== e_dout || dout_valid !== e_vld || frame_done !== e_fd || load_ready !== e_rdy || busy !== e_vld) begin
                errors++; $display("FAIL rand cyc=%0d got dout=%b vld=%b fd=%b rdy=%b busy=%b exp %b,%b,%b,%b,%b",
                                   c, dout, dout_valid, frame_done, load_ready, busy, e_dout, e_vld, e_fd, e_rdy, e_vld);
            end
        end
        for (int c = 0; c < 20; c++) tick(1'b0, 8'h00);
        checks++; if (dout_valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL rand_drain got vld=%b pending=%0d exp 0,0", dout_valid, q.size()); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_last_edge_load();
        test_mid_frame_reset();
        test_lsb_first();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
